btc_wb_initiator: RTL

BTC_WB_INITIATOR -- requirements
Module: btc_wb_initiator

---
 rtl/btc_wb_pkg.sv | 20 ++
 rtl/btc_wb_timeout.sv | 27 ++
 rtl/btc_wb_initiator.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/btc_wb_pkg.sv
// Shared encodings for the Wishbone initiator: FSM states, response status codes
// and the fixed classic-cycle CTI/BTE values.
package btc_wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUS  = 2'b01,
    ST_GAP  = 2'b10,
    ST_RESP = 2'b11
  } state_t;

  localparam logic [1:0] STATUS_OK       = 2'b00;
  localparam logic [1:0] STATUS_ERR      = 2'b01;
  localparam logic [1:0] STATUS_RTY_EXH  = 2'b10;
  localparam logic [1:0] STATUS_TIMEOUT  = 2'b11;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

endpackage

// File: rtl/btc_wb_timeout.sv
// Counts bus cycles that pass without a termination; expired marks the cycle
// in which the TIMEOUT-th such cycle is reached.
module btc_wb_timeout #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [15:0] LAST = 16'(TIMEOUT - 1);

  logic [15:0] count;

  assign expired = enable && (count == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/btc_wb_initiator.sv
// Single-outstanding Wishbone classic initiator: accepts one command, runs the
// bus cycle with retry/timeout handling and returns one response.
module btc_wb_initiator
  import btc_wb_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int TIMEOUT   = 255,
  parameter int MAX_RETRY = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  input  logic [3:0]        cmd_sel,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic [1:0]        rsp_status,
  output logic              wb_cycle,
  output logic              wb_strobe,
  output logic              wb_we,
  output logic [3:0]        wb_sel,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [31:0]       wb_wdata,
  output logic [2:0]        wb_cti,
  output logic [1:0]        wb_bte,
  input  logic              wb_ack,
  input  logic              wb_err,
  input  logic              wb_rty,
  input  logic [31:0]       wb_rdata,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  state_t            state, state_n;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        sel_q;
  logic [RW-1:0]     retry_q;
  logic [31:0]       rdata_q, rdata_n;
  logic [1:0]        status_q, status_n;
  logic              load_rsp, retry_inc, accept, expired, term;

  // Handshakes: a transfer happens on any rising edge where valid && ready;
  // cmd_ready depends only on state, and rsp_* hold until rsp_ready.
  assign accept    = cmd_valid && (state == ST_IDLE);
  assign term      = wb_err || wb_ack || wb_rty;
  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign wb_cycle  = (state == ST_BUS);
  assign wb_strobe = (state == ST_BUS);
  assign rsp_valid = (state == ST_RESP);
  assign wb_we     = we_q;
  assign wb_addr   = addr_q;
  assign wb_wdata  = wdata_q;
  assign wb_sel    = sel_q;
  assign wb_cti    = CTI_CLASSIC;
  assign wb_bte    = BTE_LINEAR;
  assign rsp_rdata = rdata_q;
  assign rsp_status = status_q;
  assign dbg_state = state;

  btc_wb_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state != ST_BUS),
    .enable  ((state == ST_BUS) && !term),
    .expired (expired)
  );

  always_comb begin
    state_n   = state;
    load_rsp  = 1'b0;
    retry_inc = 1'b0;
    rdata_n   = '0;
    status_n  = STATUS_OK;
    case (state)
      ST_IDLE: if (cmd_valid) state_n = ST_BUS;
      ST_BUS: begin
        // err beats ack beats rty; any termination beats the timeout
        if (wb_err) begin
          state_n  = ST_RESP;
          load_rsp = 1'b1;
          status_n = STATUS_ERR;
        end else if (wb_ack) begin
          state_n  = ST_RESP;
          load_rsp = 1'b1;
          rdata_n  = we_q ? 32'd0 : wb_rdata;
        end else if (wb_rty) begin
          if (retry_q == RW'(MAX_RETRY)) begin
            state_n  = ST_RESP;
            load_rsp = 1'b1;
            status_n = STATUS_RTY_EXH;
          end else begin
            state_n   = ST_GAP;
            retry_inc = 1'b1;
          end
        end else if (expired) begin
          state_n  = ST_RESP;
          load_rsp = 1'b1;
          status_n = STATUS_TIMEOUT;
        end
      end
      ST_GAP:  state_n = ST_BUS;
      ST_RESP: if (rsp_ready) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      sel_q    <= '0;
      retry_q  <= '0;
      rdata_q  <= '0;
      status_q <= STATUS_OK;
    end else begin
      state <= state_n;
      if (accept) begin
        we_q    <= cmd_we;
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        sel_q   <= cmd_sel;
        retry_q <= '0;
      end
      if (retry_inc) retry_q <= retry_q + RW'(1);
      if (load_rsp) begin
        rdata_q  <= rdata_n;
        status_q <= status_n;
      end
    end
  end

endmodule
